// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter for the shared Avalon-style memory bus; one transaction owns the slave at a time.
// Optional round-robin contention policy enabled by defining BUS_ARB_ROUND_ROBIN_EN (default: m0 fixed priority).
module mips_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant,
  output logic [1:0]  o_dbg_state,
  output logic        o_dbg_last_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_grant;
  logic   w_last_grant_next;
  logic   w_req0;
  logic   w_req1;

  // Handshake: a master holds read/write (and its address/data) until a cycle where its
  // waitrequest is low; that cycle completes the transfer and returns readdata.
  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_last_grant_next = r_last_grant;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
          w_next = r_last_grant ? OWN0 : OWN1;
`else
          w_next = OWN0;
`endif
        end else if (w_req0) begin
          w_next = OWN0;
        end else if (w_req1) begin
          w_next = OWN1;
        end
      end
      OWN0: begin
        // A dropped request is an abort: leave without recording a grant.
        if (!w_req0) begin
          w_next = IDLE;
        end else if (!s_waitrequest) begin
          w_next            = IDLE;
          w_last_grant_next = 1'b0;
        end
      end
      OWN1: begin
        if (!w_req1) begin
          w_next = IDLE;
        end else if (!s_waitrequest) begin
          w_next            = IDLE;
          w_last_grant_next = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_address      = 32'h0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = 32'h0;
    s_byteenable   = 4'h0;
    grant          = 2'b00;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (r_state)
      OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read & ~m0_write;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        grant          = 2'b01;
        m0_waitrequest = s_waitrequest;
      end
      OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read & ~m1_write;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        grant          = 2'b10;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign o_dbg_state      = r_state;
  assign o_dbg_last_grant = r_last_grant;

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter sharing the single-ported Avalon-style memory bus (RAM_32x4096 or external memory) between two bus masters, e.g. the CPU data/instruction port (m0) and a loader/DMA or second fetch port (m1). Grants exactly one transaction at a time and forwards the owner's signals to the slave. Non-owners are held off with waitrequest. Sits between the masters and the memory in the `mips_cpu_bus` top level and testbenches.

## Interface
- No parameters; address/data are 32 bits, byteenable 4 bits.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- m0_address, m1_address  in  32  master byte addresses.
- m0_read, m1_read  in  1  read request.
- m0_write, m1_write  in  1  write request.
- m0_writedata, m1_writedata  in  32  write data.
- m0_byteenable, m1_byteenable  in  4  byte lanes.
- m0_waitrequest, m1_waitrequest  out  1  stall to each master.
- m0_readdata, m1_readdata  out  32  read data to each master.
- s_address  out  32  to slave.
- s_read, s_write  out  1  to slave.
- s_writedata  out  32  to slave.
- s_byteenable  out  4  to slave.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  32  slave read data, valid in the cycle s_waitrequest is low.
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 00 when idle.

## Operation
- Request: master x requests when mx_read | mx_write. If both are high, the transaction is a write and s_read is forced to 0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - All s_* outputs are 0; grant is 00; both mx_waitrequest are 1.
  - When one or both masters request, go to OWN0 or OWN1 at the next edge, choosing the owner by the priority rule below.
  - With no requests, stay in IDLE.
- OWNx:
  - s_address, s_read, s_write, s_writedata and s_byteenable mirror master x combinationally.
  - mx_waitrequest = s_waitrequest.
  - The other master's waitrequest is 1.
  - grant = one-hot x.
- Completion: an edge in OWNx where master x requests and s_waitrequest = 0. The FSM returns to IDLE and last_grant ← x.
- Abort: if master x drops its request while in OWNx, return to IDLE without updating last_grant. The slave sees the request drop in the same cycle.
- mx_readdata = s_readdata for both masters. It is meaningful only to the owner in its completion cycle.
- Internal state: the FSM and a 1-bit last_grant register only; no data buffering.

## Timing
- Reset (asynchronous):
  - State goes to IDLE, last_grant ← 1, so m0 wins the first contested cycle.
  - Outputs immediately take their IDLE values: s_* = 0, grant = 00, mx_waitrequest = 1.
- Reset mid-transaction: the slave request drops at once and the transaction is discarded. The master must reissue it.
- Arbitration latency: 1 cycle from request (sampled in IDLE) to OWNx.
- Minimum transaction: 2 cycles, IDLE then OWNx, with a zero-wait slave.
- One idle bubble always separates consecutive grants, including back-to-back grants to the same master.
- Slave wait states extend OWNx indefinitely. The grant is never revoked while s_waitrequest = 1.
- Ownership changes only at an edge out of IDLE.

## Configuration
- BUS_ARB_ROUND_ROBIN_EN defined:
  - When both masters request in IDLE, grant the master ≠ last_grant.
  - A single requester is always granted.
- BUS_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: m0 always wins when both request.
  - last_grant is still maintained but unused.
  - m1 may starve under continuous m0 traffic.

## Test plan
- Reset, single master: reset, then m0_read at 0xBFC00000 with a zero-wait RAM holding 0x3C03BFC0 there.
  - Required: grant = 01 one cycle later.
  - m0_readdata = 0x3C03BFC0 with m0_waitrequest = 0 in that cycle.
  - IDLE on the following cycle.
- Wait states: slave holds s_waitrequest high 3 cycles during an m1 write of 0xDEADBEEF, byteenable 0xF.
  - Required: grant stays 10 for 4 cycles.
  - s_* mirrors m1 throughout.
  - m0 requesting meanwhile sees waitrequest = 1; a read-back returns 0xDEADBEEF.
- Contention with BUS_ARB_ROUND_ROBIN_EN: both masters request continuously for 6 transactions.
  - Required: grant sequence 01,10,01,10,01,10, with IDLE bubbles between grants.
- Contention without the macro: the same stimulus.
  - Required: grant = 01 for all 6 transactions; m1_waitrequest stays 1 throughout.
- Simultaneous read and write: m0_read = m0_write = 1.
  - Required: s_write = 1, s_read = 0.
- Abort and reset:
  - m0 drops its request in OWN0 → next state IDLE, last_grant unchanged.
  - reset asserted mid-OWN1 with slave waiting → s_read and s_write fall to 0 and grant to 00 before the next clock edge.
